// File: rtl/mc_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register map,
// CONTROL/STATUS bit positions and the per-channel write strobe bundle.
package mc_timer_pkg;

  localparam int MAX_CH = 8;

  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_CONTROL  = 2'd1;
  localparam logic [1:0] REG_PERIOD   = 2'd2;
  localparam logic [1:0] REG_SNAPSHOT = 2'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snapshot;
  } ch_wr_t;

endpackage

// File: rtl/mc_interval_timer_if.sv
// Register-bus bundle of the interval timer; lets a bench or parent block
// carry the slave bus and interrupt lines as one object.
interface mc_interval_timer_if #(
  parameter int NUM_CH = 4
);
  localparam int AW = $clog2(NUM_CH) + 2;

  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq_vec, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq_vec, irq
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: down-counter with RUN/TO state, CONTROL, PERIOD and
// SNAPSHOT registers, advanced by the shared prescaler tick.
module timer_channel
  import mc_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  ch_wr_t           wr,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snapshot,
  output logic [3:0]       control,
  output logic             run,
  output logic             to,
  output logic             irq
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] snapshot_reg;
  logic [3:0]       control_reg;
  logic             run_reg;
  logic             run_next;
  logic             to_reg;
  logic             force_reload_reg;
  logic             zero_reg;
  logic             count_zero;
  logic             timeout_evt;
  logic             unused_wdata;

  // Only the low CNT_W bits of a PERIOD write are stored.
  assign unused_wdata = ^wdata;

  assign count_zero  = (count_reg == '0);
  assign timeout_evt = count_zero && !zero_reg;

  // Later assignments take priority: START overrides every stop cause.
  always_comb begin
    run_next = run_reg;
    if (run_reg && count_zero && !control_reg[CTRL_CONT]) run_next = 1'b0;
    if (force_reload_reg)                                 run_next = 1'b0;
    if (wr.control && wdata[CTRL_STOP])                   run_next = 1'b0;
    if (wr.control && wdata[CTRL_START])                  run_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg        <= CNT_W'(RESET_PERIOD);
      period_reg       <= CNT_W'(RESET_PERIOD);
      snapshot_reg     <= '0;
      control_reg      <= '0;
      run_reg          <= 1'b0;
      to_reg           <= 1'b0;
      force_reload_reg <= 1'b0;
      zero_reg         <= 1'b0;
    end else begin
      force_reload_reg <= wr.period;
      zero_reg         <= count_zero;
      run_reg          <= run_next;
      if (wr.period)   period_reg   <= wdata[CNT_W-1:0];
      if (wr.control)  control_reg  <= wdata[3:0];
      if (wr.snapshot) snapshot_reg <= count_reg;

      // A one-shot channel parks at zero instead of reloading.
      if (force_reload_reg) begin
        count_reg <= period_reg;
      end else if (tick && run_reg) begin
        if (!count_zero)                   count_reg <= count_reg - CNT_W'(1);
        else if (control_reg[CTRL_CONT])   count_reg <= period_reg;
      end

      if (wr.status)        to_reg <= 1'b0;
      else if (timeout_evt) to_reg <= 1'b1;
    end
  end

  assign period   = period_reg;
  assign snapshot = snapshot_reg;
  assign control  = control_reg;
  assign run      = run_reg;
  assign to       = to_reg;
  assign irq      = to_reg && control_reg[CTRL_ITO];

endmodule

// File: rtl/mc_interval_timer.sv
// Multi-channel interval timer: shared prescaler, register decode and
// registered read mux around NUM_CH independent timer_channel instances.
module mc_interval_timer
  import mc_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESCALE     = 1,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+1:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic                       irq
);

  localparam int AW   = $clog2(NUM_CH) + 2;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             tick;
  logic [1:0]       reg_sel;
  logic [CH_W-1:0]  ch_idx;
  logic             ch_valid;
  logic             wr_en;
  logic [31:0]      readdata_reg;
  logic [31:0]      rd_next;

  logic [CNT_W-1:0] period_arr [NUM_CH];
  logic [CNT_W-1:0] snap_arr   [NUM_CH];
  logic [3:0]       ctrl_arr   [NUM_CH];
  logic [NUM_CH-1:0] run_vec;
  logic [NUM_CH-1:0] to_vec;

  generate
    if (PRESCALE == 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int PS_W = $clog2(PRESCALE);
      logic [PS_W-1:0] pre_cnt_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               pre_cnt_reg <= '0;
        else if (pre_cnt_reg == PS_W'(PRESCALE-1))  pre_cnt_reg <= '0;
        else                                        pre_cnt_reg <= pre_cnt_reg + PS_W'(1);
      end
      assign tick = (pre_cnt_reg == PS_W'(PRESCALE-1));
    end
  endgenerate

  assign reg_sel = address[1:0];

  // Channel field can address more slots than exist when NUM_CH is not a power of two.
  generate
    if (NUM_CH > 1) begin : g_chsel
      assign ch_idx   = address[AW-1:2];
      assign ch_valid = (int'(address[AW-1:2]) < NUM_CH);
    end else begin : g_onech
      assign ch_idx   = '0;
      assign ch_valid = 1'b1;
    end
  endgenerate

  assign wr_en = chipselect && !write_n && ch_valid;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic   sel;
      ch_wr_t wr;
      assign sel         = wr_en && (ch_idx == CH_W'(gi));
      assign wr.status   = sel && (reg_sel == REG_STATUS);
      assign wr.control  = sel && (reg_sel == REG_CONTROL);
      assign wr.period   = sel && (reg_sel == REG_PERIOD);
      assign wr.snapshot = sel && (reg_sel == REG_SNAPSHOT);

      timer_channel #(
        .CNT_W        (CNT_W),
        .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .wr       (wr),
        .wdata    (writedata),
        .period   (period_arr[gi]),
        .snapshot (snap_arr[gi]),
        .control  (ctrl_arr[gi]),
        .run      (run_vec[gi]),
        .to       (to_vec[gi]),
        .irq      (irq_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_next = '0;
    if (ch_valid) begin
      case (reg_sel)
        REG_STATUS: begin
          rd_next[STAT_RUN] = run_vec[ch_idx];
          rd_next[STAT_TO]  = to_vec[ch_idx];
        end
        REG_CONTROL: rd_next[3:0] = ctrl_arr[ch_idx];
        REG_PERIOD:  rd_next = 32'(period_arr[ch_idx]);
        default:     rd_next = 32'(snap_arr[ch_idx]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_reg <= '0;
    else          readdata_reg <= rd_next;
  end

  assign readdata = readdata_reg;
  assign irq      = |irq_vec;

endmodule

// File: doc/mc_interval_timer.md
MC_INTERVAL_TIMER -- requirements
Module: mc_interval_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter and period width in bits (8..32).
REQ-003 SHALL have parameter PRESCALE, default 1, fixed clock divisor applied to all channels (1..256).
REQ-004 SHALL have parameter RESET_PERIOD, default 49999, period and counter value after reset.
REQ-005 SHALL have port clk, input, 1, clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port address, input, clog2(NUM_CH)+2, word address: {channel, reg}.
REQ-008 SHALL have port chipselect, input, 1, slave select.
REQ-009 SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, write data.
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port irq_vec, output, NUM_CH, per-channel interrupt.
REQ-013 SHALL have port irq, output, 1, OR of irq_vec.

Function
REQ-014 SHALL decode reg offsets per channel: 0 STATUS {RUN[1],TO[0]}; 1 CONTROL {STOP[3],START[2],CONT[1],ITO[0]}; 2 PERIOD; 3 SNAPSHOT.
REQ-015 SHALL register readdata every cycle from the addressed register, 1-cycle latency, unused bits zero, CNT_W values zero-extended.
REQ-016 SHALL return 0 and ignore writes for channel index >= NUM_CH.
REQ-017 SHALL generate a shared tick: prescale counter 0..PRESCALE-1, tick when at PRESCALE-1, tick every cycle when PRESCALE=1; it free-runs from reset.
REQ-018 SHALL, per channel on tick while RUN: load PERIOD when counter is zero, else decrement by 1.
REQ-019 SHALL, on a PERIOD write, store writedata[CNT_W-1:0], assert force_reload next cycle, load the counter with PERIOD on that cycle regardless of tick, and clear RUN.
REQ-020 SHALL store CONTROL[3:0] on write; START=1 sets RUN next cycle; STOP=1 clears RUN; START wins over STOP in the same write; START wins over force_reload and one-shot stop.
REQ-021 SHALL clear RUN when counter is zero and CONT=0 (one-shot), counter left at zero.
REQ-022 SHALL set TO on the rising edge of counter==0 (registered edge detect); a STATUS write clears TO; clear wins over a simultaneous timeout event.
REQ-023 SHALL drive irq_vec[i] = TO[i] AND ITO[i], combinational from registers.
REQ-024 SHALL, on any SNAPSHOT write, copy the live counter into SNAPSHOT next cycle; reads return the latched value.
REQ-025 SHALL keep channels fully independent; simultaneous events in different channels do not interact.

Reset
REQ-026 SHALL on reset_n low set: counters and PERIOD = RESET_PERIOD, CONTROL/RUN/TO/SNAPSHOT/force_reload/edge detect = 0, prescale counter = 0, readdata = 0, irq = 0, irq_vec = 0.
REQ-027 SHALL abort any counting on reset mid-operation; no timeout is raised on reset release.

Structure
REQ-028 SHALL place register offsets, CONTROL/STATUS bit positions and the max-channel constant in package mc_timer_pkg.
REQ-029 SHALL implement one channel in sub-module timer_channel (counter, RUN, TO, CONTROL, PERIOD, SNAPSHOT), instantiated NUM_CH times by generate; top owns prescaler, decode and read mux.

Verification
REQ-030 SHALL cover: PRESCALE=1, ch0 PERIOD=3, CONTROL=0x7 -> counter 3,2,1,0,3…; TO and irq_vec[0] set 4 cycles after start; STATUS write clears irq.
REQ-031 SHALL cover: CONTROL=0x5 (one-shot), PERIOD=2 -> RUN drops when counter reaches 0, counter holds 0, TO=1 once.
REQ-032 SHALL cover: PRESCALE=4, PERIOD=1, continuous -> timeout every 8 clk cycles.
REQ-033 SHALL cover: ch2 running, write SNAPSHOT at counter 0x10 -> SNAPSHOT read returns 0x10; ch1/ch3 registers unchanged.
REQ-034 SHALL cover: STATUS write coincident with timeout event -> TO stays 0; CONTROL write 0xC -> RUN=1.
REQ-035 SHALL cover: reset_n pulsed mid-count -> all outputs 0, PERIOD reads 49999, read of channel index NUM_CH returns 0.
